// File: rtl/pipe_event_monitor.sv
// Pipeline event monitor: per-channel event counters plus a RUN-cycle counter.
// Define PIPE_EVENT_MONITOR_SATURATE_EN to saturate counters instead of wrapping.
module pipe_event_monitor #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int SEL_W  = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              clear_i,
    input  logic [NUM_CH-1:0] event_i,
    input  logic [CNT_W-1:0]  limit_i,
    input  logic [SEL_W-1:0]  rd_sel_i,
    output logic [CNT_W-1:0]  cnt_o,
    output logic [CNT_W-1:0]  cycle_o,
    output logic [NUM_CH-1:0] ovf_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt [NUM_CH];
    logic [CNT_W-1:0]   r_cycle;
    logic [NUM_CH-1:0]  r_ovf;
    logic               r_busy;
    logic               r_done;
    logic [CNT_W-1:0]   w_cyc_nxt;
    logic               w_lim_on;

    function automatic logic [CNT_W-1:0] f_inc(input logic [CNT_W-1:0] v);
`ifdef PIPE_EVENT_MONITOR_SATURATE_EN
        return (&v) ? v : v + CNT_W'(1);
`else
        return v + CNT_W'(1);
`endif
    endfunction

    assign w_cyc_nxt = f_inc(r_cycle);
    assign w_lim_on  = (limit_i != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cycle <= '0;
            r_ovf   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) r_cnt[k] <= '0;
        end else if (clear_i) begin
            r_state <= S_IDLE;
            r_cycle <= '0;
            r_ovf   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) r_cnt[k] <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!start_i) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_lim_on && (r_cycle >= limit_i)) begin
                        // Limit was lowered below the count while paused.
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cycle <= w_cyc_nxt;
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (event_i[k]) begin
                                r_cnt[k] <= f_inc(r_cnt[k]);
                                if (&r_cnt[k]) r_ovf[k] <= 1'b1;
                            end
                        end
                        if (w_lim_on && (w_cyc_nxt == limit_i)) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Out-of-range selects match no channel and read as zero.
    always_comb begin
        cnt_o = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd_sel_i == SEL_W'(k)) cnt_o = r_cnt[k];
        end
    end

    assign cycle_o = r_cycle;
    assign ovf_o   = r_ovf;
    assign busy_o  = r_busy;
    assign done_o  = r_done;

endmodule

// File: tb/tb_pipe_event_monitor.sv
// Bench for pipe_event_monitor: 4-bit counters, a 4-channel and a 3-channel
// instance on shared stimulus, checked against an unbounded-count model.
module tb_pipe_event_monitor;

    logic       clk;
    logic       rst;
    logic       start;
    logic       clear;
    logic [3:0] ev;
    logic [3:0] limit;
    logic [1:0] sel;

    logic [3:0] a_cnt, a_cyc, a_ovf;
    logic       a_busy, a_done;
    logic [3:0] b_cnt, b_cyc;
    logic [2:0] b_ovf;
    logic       b_busy, b_done;

    int checks = 0;
    int errors = 0;

    pipe_event_monitor #(.NUM_CH(4), .CNT_W(4), .SEL_W(2)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
        .event_i(ev), .limit_i(limit), .rd_sel_i(sel),
        .cnt_o(a_cnt), .cycle_o(a_cyc), .ovf_o(a_ovf),
        .busy_o(a_busy), .done_o(a_done)
    );

    pipe_event_monitor #(.NUM_CH(3), .CNT_W(4), .SEL_W(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
        .event_i(ev[2:0]), .limit_i(limit), .rd_sel_i(sel),
        .cnt_o(b_cnt), .cycle_o(b_cyc), .ovf_o(b_ovf),
        .busy_o(b_busy), .done_o(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: true (unbounded) event/cycle totals plus a mode word.
    int unsigned n_ev [4];
    int unsigned n_cyc;
    int          mode; // 0 idle, 1 run, 2 done

    function automatic logic [3:0] shown(input int unsigned n);
`ifdef PIPE_EVENT_MONITOR_SATURATE_EN
        return (n > 15) ? 4'd15 : n[3:0];
`else
        return n[3:0];
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            n_cyc = 0;
            mode  = 0;
            for (int k = 0; k < 4; k++) n_ev[k] = 0;
        end else if (mode == 0) begin
            if (start) mode = 1;
        end else if (mode == 1) begin
            if (!start) mode = 0;
            else if (limit != 0 && shown(n_cyc) >= limit) mode = 2;
            else begin
                n_cyc++;
                for (int k = 0; k < 4; k++) if (ev[k]) n_ev[k]++;
                if (limit != 0 && shown(n_cyc) == limit) mode = 2;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_ovf();
        int v = 0;
        for (int k = 0; k < 4; k++) if (n_ev[k] > 15) v |= (1 << k);
        return v;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("a_cnt", a_cnt, shown(n_ev[sel]));
            chk("a_cyc", a_cyc, shown(n_cyc));
            chk("a_ovf", a_ovf, exp_ovf());
            chk("a_busy", a_busy, mode == 1);
            chk("a_done", a_done, mode == 2);
            chk("b_cnt", b_cnt, (sel < 3) ? shown(n_ev[sel]) : 0);
            chk("b_cyc", b_cyc, shown(n_cyc));
            chk("b_ovf", b_ovf, exp_ovf() & 7);
            chk("b_busy", b_busy, mode == 1);
            chk("b_done", b_done, mode == 2);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rdch(input int ch, input int exp, input string nm);
        sel = ch[1:0];
        #1;
        chk(nm, a_cnt, exp);
    endtask

    task automatic do_clear();
        start = 0;
        ev    = 0;
        clear = 1;
        tick();
        clear = 0;
    endtask

    initial begin
        rst = 1; start = 0; clear = 0; ev = 0; limit = 0; sel = 0;
        tick(2);
        rst = 0;
        #1;
        chk("rst_cyc", a_cyc, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_ovf", a_ovf, 0);

        // Ten RUN edges with channels 0 and 1 active.
        start = 1; ev = 4'b0011;
        tick(11);
        rdch(0, 10, "r32_ch0");
        rdch(1, 10, "r32_ch1");
        rdch(2, 0, "r32_ch2");
        rdch(3, 0, "r32_ch3");
        chk("r32_cyc", a_cyc, 10);
        chk("r32_busy", a_busy, 1);
        start = 0;
        tick();
        chk("pause_busy", a_busy, 0);
        do_clear();

        // Limit of five.
        sel = 0; limit = 5; ev = 4'b0001; start = 1;
        tick(6);
        chk("r33_done", a_done, 1);
        chk("r33_cyc", a_cyc, 5);
        chk("r33_ch0", a_cnt, 5);
        tick(3);
        chk("r33_hold", a_cnt, 5);

        // Clear beats start in DONE.
        clear = 1;
        tick();
        chk("r36_done", a_done, 0);
        chk("r36_busy", a_busy, 0);
        chk("r36_cyc", a_cyc, 0);
        chk("r36_cnt", a_cnt, 0);
        clear = 0; start = 0; limit = 0;
        tick();

        // Pause and resume.
        sel = 2; ev = 4'b0100; start = 1;
        tick(4);
        start = 0;
        tick(4);
        start = 1;
        tick(3);
        chk("r34_ch2", a_cnt, 5);
        chk("r34_cyc", a_cyc, 5);
        do_clear();

        // Limit lowered below count while paused.
        sel = 0; ev = 4'b0001; start = 1;
        tick(5);
        start = 0;
        tick();
        limit = 2; start = 1;
        tick(2);
        chk("r22_done", a_done, 1);
        chk("r22_cyc", a_cyc, 4);
        chk("r22_ch0", a_cnt, 4);
        do_clear();
        limit = 0;

        // Overflow of channel 1 and cycle counter.
        sel = 1; ev = 4'b0010; start = 1;
        tick(18);
        chk("r35_ovf1", a_ovf[1], 1);
`ifdef PIPE_EVENT_MONITOR_SATURATE_EN
        chk("r35_ch1", a_cnt, 15);
`else
        chk("r35_ch1", a_cnt, 1);
`endif
        do_clear();

        // Out-of-range select on the 3-channel instance.
        ev = 4'b1111; start = 1;
        tick(4);
        rdch(3, 3, "sel3_a");
        chk("sel3_b", b_cnt, 0);

        // Asynchronous reset between edges.
        #2;
        rst = 1;
        #1;
        chk("r37_a_cnt", a_cnt, 0);
        chk("r37_a_cyc", a_cyc, 0);
        chk("r37_a_busy", a_busy, 0);
        chk("r37_a_ovf", a_ovf, 0);
        chk("r37_b_cyc", b_cyc, 0);
        rst = 0;
        tick(2);
        chk("r30_cyc", a_cyc, 1);
        chk("r30_ch3", a_cnt, 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_event_monitor.md
PIPE_EVENT_MONITOR -- requirements
Module: pipe_event_monitor

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent event channels (e.g. stall, flush, branch, load-use); legal range 1..16.
REQ-002 Parameter CNT_W, default 32: width of every event counter and the cycle counter; legal range 4..32.
REQ-003 Parameter SEL_W, default 2: width of rd_sel_i; SEL_W = ceil(log2(NUM_CH)), minimum 1.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk_i  input  1  clock; all state changes on its rising edge.
REQ-006 rst_i  input  1  asynchronous active-high reset.
REQ-007 start_i  input  1  run enable; level-sensitive.
REQ-008 clear_i  input  1  synchronous clear of all counters and flags.
REQ-009 event_i  input  NUM_CH  per-channel event strobes, one count per high cycle.
REQ-010 limit_i  input  CNT_W  cycle limit; 0 = unlimited.
REQ-011 rd_sel_i  input  SEL_W  readback channel select.
REQ-012 cnt_o  output  CNT_W  count of channel rd_sel_i.
REQ-013 cycle_o  output  CNT_W  counted RUN cycles.
REQ-014 ovf_o  output  NUM_CH  sticky per-channel overflow flags.
REQ-015 busy_o  output  1  high in RUN state.
REQ-016 done_o  output  1  high in DONE state.

Function
REQ-017 FSM states IDLE, RUN, DONE; IDLE after reset.
REQ-018 IDLE: start_i=1 -> RUN next edge; counters hold; nothing counted in IDLE.
REQ-019 RUN: cycle_o +1 per edge; channel k +1 per edge where event_i[k]=1; all channels update in parallel, independently.
REQ-020 RUN with start_i=0 -> IDLE (pause); counts, cycle_o and flags held; later start_i=1 resumes from held values.
REQ-021 RUN, limit_i!=0, edge where cycle_o becomes equal to limit_i: that cycle's events are counted, then state -> DONE.
REQ-022 RUN entered with cycle_o >= limit_i!=0 (limit lowered while paused): -> DONE on next edge, no counting that edge.
REQ-023 DONE: all counters and flags frozen; start_i and event_i ignored; leave only via clear_i or rst_i.
REQ-024 clear_i=1 at an edge: all counters, cycle_o and ovf_o -> 0, state -> IDLE, events of that cycle discarded; clear_i has priority over start_i and limit detection in every state.
REQ-025 cnt_o combinational from counter[rd_sel_i]; rd_sel_i >= NUM_CH -> cnt_o = 0.
REQ-026 Overflow: increment of a counter at all-ones sets its ovf_o bit (sticky until clear/reset); wrap or saturate per REQ-031.
REQ-027 cycle_o follows the same overflow rule; it has no flag; with limit_i=0 it never causes DONE.
REQ-028 busy_o and done_o are registered state decodes, never both high.

Reset
REQ-029 rst_i=1: immediately, independent of clk_i, state=IDLE, all counters=0, cycle_o=0, ovf_o=0, busy_o=0, done_o=0, cnt_o=0.
REQ-030 Reset mid-RUN or in DONE discards all counts; first counted edge is the one after rst_i falls and RUN is entered.

Configuration
REQ-031 Macro PIPE_EVENT_MONITOR_SATURATE_EN: defined -> counters and cycle_o hold at 2^CNT_W-1 on overflow; undefined -> they wrap to 0; ovf_o is set identically in both builds.

Verification
REQ-032 Reset, start_i=1, event_i=4'b0011 for 10 RUN edges, limit_i=0 -> ch0=ch1=10, ch2=ch3=0, cycle_o=10, busy_o=1.
REQ-033 limit_i=5, start_i=1, event_i[0] high every edge -> DONE after 5th RUN edge, cycle_o=5, ch0=5, done_o=1; further events leave ch0=5.
REQ-034 Run 3 edges, start_i=0 for 4 edges, start_i=1 for 2 edges with event_i[2]=1 throughout -> ch2=5, cycle_o=5.
REQ-035 CNT_W=4, event_i[1] high 17 RUN edges -> ovf_o[1]=1; ch1=1 without macro, ch1=15 with PIPE_EVENT_MONITOR_SATURATE_EN.
REQ-036 clear_i and start_i both high in DONE -> next edge IDLE, all counts 0, ovf_o=0, done_o=0; rd_sel_i=NUM_CH (NUM_CH=3) -> cnt_o=0.
REQ-037 rst_i pulsed between clock edges mid-RUN -> all outputs 0 before next rising edge of clk_i.
